// File: rtl/first_nios2_system_sysid_checker_pkg.sv
// Shared definitions for the system ID checker.
// Holds the FSM state encoding, the sysid slave word addresses and a
// word-compare helper that the top uses for the ID and timestamp checks.
package first_nios2_system_sysid_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Returns 1 when the word read from the slave differs from the build-time value.
  function automatic logic word_mismatch(input logic [31:0] i_seen, input logic [31:0] i_expected);
    return (i_seen != i_expected);
  endfunction

endpackage

// File: rtl/first_nios2_system_sysid_checker_timeout.sv
// Stall counter for one Avalon read.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_clear        : reload the count with zero (entry to a read state)
//   i_en           : count this cycle (read stalled by waitrequest)
//   o_expired      : this stalled cycle is the LIMIT-th one in a row
module first_nios2_system_sysid_checker_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

  logic [15:0] r_count;

  // Expiry is flagged combinationally on the LIMIT-th stalled cycle so the
  // FSM can drop the read at the end of that same cycle.
  assign o_expired = i_en && (r_count == LIMIT_M1);

  // Stall count: reload on clear, increment while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_en) begin
      r_count <= r_count + 16'd1;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that checks the system ID slave before the CPU is
// released. Reads the ID word (address 0) then the timestamp word (address 1),
// compares both to build-time values and latches the result.
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   start               : one-cycle pulse, accepted only in IDLE
//   avm_address/avm_read: registered read request to the sysid slave
//   avm_waitrequest     : slave stall
//   avm_readdata        : read data, sampled when read=1 and waitrequest=0
//   busy/done/pass      : check status (done and pass sticky until next start)
//   id_mismatch/ts_mismatch/timeout : individual failure flags
//   captured_id/captured_ts         : last words read
module first_nios2_system_sysid_checker
  import first_nios2_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1380749419,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_e      r_state, w_state_next;
  logic        r_read, r_addr, r_busy, r_done, r_pass;
  logic        r_id_mm, r_ts_mm, r_timeout, r_auto_pending;
  logic [31:0] r_cap_id, r_cap_ts;

  logic        w_read_next, w_addr_next, w_busy_next, w_done_next, w_pass_next;
  logic        w_id_mm_next, w_ts_mm_next, w_timeout_next, w_auto_next;
  logic [31:0] w_cap_id_next, w_cap_ts_next;
  logic        w_cnt_clear, w_cnt_en, w_expired, w_ts_diff;

  assign w_cnt_en  = ((r_state == ST_RD_ID) || (r_state == ST_RD_TS)) && avm_waitrequest;
  assign w_ts_diff = word_mismatch(avm_readdata, EXPECTED_TIMESTAMP);

  first_nios2_system_sysid_checker_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (clock),
    .i_rst_n  (reset_n),
    .i_clear  (w_cnt_clear),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_next   = r_state;
    w_read_next    = 1'b0;
    w_addr_next    = r_addr;
    w_busy_next    = r_busy;
    w_done_next    = r_done;
    w_pass_next    = r_pass;
    w_id_mm_next   = r_id_mm;
    w_ts_mm_next   = r_ts_mm;
    w_timeout_next = r_timeout;
    w_cap_id_next  = r_cap_id;
    w_cap_ts_next  = r_cap_ts;
    w_auto_next    = r_auto_pending;
    w_cnt_clear    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || r_auto_pending) begin
          w_state_next   = ST_RD_ID;
          w_read_next    = 1'b1;
          w_addr_next    = SYSID_ADDR_ID;
          w_busy_next    = 1'b1;
          w_done_next    = 1'b0;
          w_pass_next    = 1'b0;
          w_id_mm_next   = 1'b0;
          w_ts_mm_next   = 1'b0;
          w_timeout_next = 1'b0;
          w_auto_next    = 1'b0;
          w_cnt_clear    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RD_ID: begin
        if (!avm_waitrequest) begin
          w_cap_id_next = avm_readdata;
          w_id_mm_next  = word_mismatch(avm_readdata, EXPECTED_ID);
          w_state_next  = ST_RD_TS;
          w_read_next   = 1'b1;
          w_addr_next   = SYSID_ADDR_TS;
          w_cnt_clear   = 1'b1;
        end else if (w_expired) begin
          // Timestamp is never read, so its mismatch flag stays clear.
          w_timeout_next = 1'b1;
          w_state_next   = ST_FINISH;
          w_busy_next    = 1'b0;
          w_done_next    = 1'b1;
          w_pass_next    = 1'b0;
        end else begin
          w_read_next = 1'b1;
        end
      end
      ST_RD_TS: begin
        if (!avm_waitrequest) begin
          w_cap_ts_next = avm_readdata;
          w_ts_mm_next  = w_ts_diff;
          w_state_next  = ST_FINISH;
          w_busy_next   = 1'b0;
          w_done_next   = 1'b1;
          w_pass_next   = !(r_id_mm | w_ts_diff | r_timeout);
        end else if (w_expired) begin
          w_timeout_next = 1'b1;
          w_state_next   = ST_FINISH;
          w_busy_next    = 1'b0;
          w_done_next    = 1'b1;
          w_pass_next    = 1'b0;
        end else begin
          w_read_next = 1'b1;
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; the auto-start request re-arms on every reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_read         <= 1'b0;
      r_addr         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_id_mm        <= 1'b0;
      r_ts_mm        <= 1'b0;
      r_timeout      <= 1'b0;
      r_cap_id       <= 32'd0;
      r_cap_ts       <= 32'd0;
      r_auto_pending <= AUTO_START;
    end else begin
      r_state        <= w_state_next;
      r_read         <= w_read_next;
      r_addr         <= w_addr_next;
      r_busy         <= w_busy_next;
      r_done         <= w_done_next;
      r_pass         <= w_pass_next;
      r_id_mm        <= w_id_mm_next;
      r_ts_mm        <= w_ts_mm_next;
      r_timeout      <= w_timeout_next;
      r_cap_id       <= w_cap_id_next;
      r_cap_ts       <= w_cap_ts_next;
      r_auto_pending <= w_auto_next;
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_mismatch = r_id_mm;
  assign ts_mismatch = r_ts_mm;
  assign timeout     = r_timeout;
  assign captured_id = r_cap_id;
  assign captured_ts = r_cap_ts;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed bench for the system ID checker. One instance runs with the default
// timeout against a modelled sysid slave; a second instance with an 8-cycle
// timeout sits behind a permanently stalled slave.
module tb_first_nios2_system_sysid_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, waitreq;
  logic [31:0] id_word, ts_word;
  logic        address, read, busy, done, pass, id_mm, ts_mm, tmo;
  logic [31:0] readdata, cap_id, cap_ts;

  logic        rst_to_n;
  logic        address_to, read_to, busy_to, done_to, pass_to, id_mm_to, ts_mm_to, tmo_to;
  logic [31:0] cap_id_to, cap_ts_to;

  int checks = 0;
  int errors = 0;

  // Zero-latency sysid slave model.
  assign readdata = address ? ts_word : id_word;

  first_nios2_system_sysid_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(address), .avm_read(read), .avm_waitrequest(waitreq),
    .avm_readdata(readdata), .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mm), .ts_mismatch(ts_mm), .timeout(tmo),
    .captured_id(cap_id), .captured_ts(cap_ts)
  );

  first_nios2_system_sysid_checker #(.TIMEOUT_CYCLES(8)) dut_to (
    .clock(clock), .reset_n(rst_to_n), .start(1'b0),
    .avm_address(address_to), .avm_read(read_to), .avm_waitrequest(1'b1),
    .avm_readdata(32'hDEADBEEF), .busy(busy_to), .done(done_to), .pass(pass_to),
    .id_mismatch(id_mm_to), .ts_mismatch(ts_mm_to), .timeout(tmo_to),
    .captured_id(cap_id_to), .captured_ts(cap_ts_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int nbusy;
    int nrd;
    int nrise;
    logic prev_done;

    reset_n  = 1'b0;
    rst_to_n = 1'b0;
    start    = 1'b0;
    waitreq  = 1'b0;
    id_word  = 32'd0;
    ts_word  = 32'd1380749419;
    tick();
    tick();

    // Reset state
    chk("rst_read", read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_addr", address, 1'b0);
    chk("rst_cap_ts", cap_ts, 32'd0);

    // 1: auto start, zero-wait slave
    reset_n = 1'b1;
    tick();
    chk("t1_read_c1", read, 1'b1);
    chk("t1_addr_c1", address, 1'b0);
    chk("t1_busy_c1", busy, 1'b1);
    tick();
    chk("t1_read_c2", read, 1'b1);
    chk("t1_addr_c2", address, 1'b1);
    tick();
    chk("t1_read_c3", read, 1'b0);
    chk("t1_busy_c3", busy, 1'b0);
    chk("t1_done_c3", done, 1'b1);
    chk("t1_pass_c3", pass, 1'b1);
    chk("t1_cap_ts", cap_ts, 32'd1380749419);
    tick();
    chk("t1_no_rerun", read, 1'b0);
    chk("t1_done_held", done, 1'b1);

    // 2: timestamp mismatch
    ts_word = 32'd1380749420;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_done_clr", done, 1'b0);
    chk("t2_busy", busy, 1'b1);
    tick();
    tick();
    chk("t2_done", done, 1'b1);
    chk("t2_pass", pass, 1'b0);
    chk("t2_ts_mm", ts_mm, 1'b1);
    chk("t2_id_mm", id_mm, 1'b0);
    chk("t2_cap_ts", cap_ts, 32'd1380749420);
    ts_word = 32'd1380749419;
    tick();

    // 3: five stall cycles on each read
    waitreq = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    for (int c = 1; c <= 13; c++) begin
      waitreq = ((c == 6) || (c == 12)) ? 1'b0 : 1'b1;
      chk("t3_read", read, (c <= 12) ? 1'b1 : 1'b0);
      if (c <= 12) chk("t3_addr", address, (c <= 6) ? 1'b0 : 1'b1);
      if (busy) nbusy++;
      tick();
    end
    waitreq = 1'b0;
    chk("t3_busy_cycles", nbusy, 32'd12);
    chk("t3_done", done, 1'b1);
    chk("t3_pass", pass, 1'b1);

    // 4: timeout after 8 stalled cycles on the ID read
    rst_to_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t4_read_high", read_to, 1'b1);
    end
    tick();
    chk("t4_read_drop", read_to, 1'b0);
    chk("t4_timeout", tmo_to, 1'b1);
    chk("t4_done", done_to, 1'b1);
    chk("t4_pass", pass_to, 1'b0);
    chk("t4_cap_id", cap_id_to, 32'd0);
    chk("t4_id_mm", id_mm_to, 1'b0);

    // 5: start during RD_TS and during FINISH is ignored
    nrd = 0;
    nrise = 0;
    prev_done = done;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (read) nrd++;
      if (done && !prev_done) nrise++;
      prev_done = done;
      start = ((c == 2) || (c == 3)) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    chk("t5_reads", nrd, 32'd2);
    chk("t5_done_rise", nrise, 32'd1);
    chk("t5_idle_read", read, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_pass", pass, 1'b1);

    // 6: asynchronous reset during a stalled ID read, then auto rerun
    waitreq = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_stalled_read", read, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_read", read, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_pass", pass, 1'b0);
    chk("t6_rst_cap_ts", cap_ts, 32'd0);
    waitreq = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    chk("t6_rerun_read", read, 1'b1);
    tick();
    tick();
    chk("t6_rerun_done", done, 1'b1);
    chk("t6_rerun_pass", pass, 1'b1);
    chk("t6_rerun_cap_ts", cap_ts, 32'd1380749419);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/first_nios2_system_sysid_checker.md
Name: first_nios2_system_sysid_checker

Overview:
Avalon-MM read master that sits directly upstream of the system ID slave and consumes its readdata. After reset, or on request, it reads the ID word (address 0) and the timestamp word (address 1). It compares both against build-time expected values and latches pass/fail status for the boot-status LEDs and the reset sequencer. This gives a hardware-only check that the loaded FPGA image matches the software build before the Nios II core is released.

Parameters:
EXPECTED_ID, 32'd0, ID word expected at address 0
EXPECTED_TIMESTAMP, 32'd1380749419, timestamp word expected at address 1
TIMEOUT_CYCLES, 255, maximum waitrequest-stalled cycles per read (1..65535)
AUTO_START, 1, 1 = start a check automatically once after reset release

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begin a check
avm_address  output  1  word address to sysid slave (0 = ID, 1 = timestamp)
avm_read  output  1  read strobe
avm_waitrequest  input  1  slave stall; tie 0 for a zero-wait slave
avm_readdata  input  32  slave read data, valid in the cycle read=1 and waitrequest=0
busy  output  1  check in progress
done  output  1  check finished; sticky until next start
pass  output  1  done and both words matched, no timeout
id_mismatch  output  1  captured ID differs from EXPECTED_ID
ts_mismatch  output  1  captured timestamp differs from EXPECTED_TIMESTAMP
timeout  output  1  a read exceeded TIMEOUT_CYCLES
captured_id  output  32  last ID word read
captured_ts  output  32  last timestamp word read

Behaviour:
- Reset: clock and reset_n only; reset is asynchronous and active-low. All outputs reset to 0. FSM enters IDLE and the timeout counter clears.
- States: IDLE, RD_ID, RD_TS, FINISH.
- Latency model: zero-latency fixed reads. avm_readdata is sampled in the same cycle that avm_read=1 and avm_waitrequest=0. No pipelined reads.
- IDLE:
  - Go to RD_ID on a start pulse.
  - With AUTO_START=1, also go to RD_ID on the first clock after reset deasserts, exactly once per reset.
  - On entry to RD_ID: clear done, pass, the mismatch flags and timeout; set busy=1.
- RD_ID:
  - avm_read=1, avm_address=0.
  - When waitrequest=0: capture captured_id; set id_mismatch=(readdata!=EXPECTED_ID); go to RD_TS.
- RD_TS:
  - avm_read=1, avm_address=1.
  - When waitrequest=0: capture captured_ts; set ts_mismatch; go to FINISH.
  - Minimum check is 2 cycles in read states with a zero-wait slave.
- Address and read are registered outputs. They are held stable while waitrequest=1, as the Avalon rules require.
- Timeout:
  - A 16-bit counter clears on entry to each read state and increments each cycle waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still 1: set timeout=1, drop avm_read, go to FINISH.
  - captured_* keep their prior values and the mismatch flag for the unread word is not updated.
- FINISH:
  - Lasts one cycle: busy=0, done=1, pass=!(id_mismatch|ts_mismatch|timeout).
  - Then return to IDLE with done/pass/flags held.
- A start pulse while busy=1 is ignored. A start pulse in FINISH is also ignored; it is accepted only in IDLE.
- Reset asserted mid-check: all state and outputs clear immediately (asynchronous). AUTO_START then reruns the check after release.
- avm_read is never 1 outside RD_ID/RD_TS.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (2-bit: IDLE=0, RD_ID=1, RD_TS=2, FINISH=3).
  - Address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1.
- One sub-module is natural: first_nios2_system_sysid_checker_timeout. It is a loadable 16-bit stall counter with clear, enable and an expired output, instantiated once.
- The comparator and capture registers stay in the top module.

Test Plan:
1. AUTO_START=1, zero-wait slave returning 0 at address 0 and 1380749419 at address 1, release reset. Required: read is high for 2 cycles (addr 0 then 1); done=1 and pass=1 at cycle 3; captured_ts=1380749419.
2. Slave returns 1380749420 at address 1, then start pulse. Required: ts_mismatch=1, id_mismatch=0, pass=0, done=1.
3. waitrequest held high for 5 cycles on each read. Required: address and read are stable throughout the stall; pass=1; busy lasts 12 cycles.
4. TIMEOUT_CYCLES=8, waitrequest stuck at 1 during the ID read. Required: read drops after 8 stalled cycles; timeout=1, pass=0, done=1; captured_id unchanged.
5. start pulsed during RD_TS. Required: ignored; exactly 2 reads issued; a single done.
6. reset_n asserted during a stalled RD_ID. Required: read, busy and flags go to 0 asynchronously; after release with AUTO_START=1 a full check reruns to pass=1.
